// File: rtl/radix4_divider_pkg.sv
// Shared definitions for the radix-4 restoring divider: default operand
// width and the controller state encoding.
package radix4_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_CALC = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/radix4_div_step.sv
// One radix-4 restoring step: given the shifted partial remainder T and the
// divisor multiples D and 3D, select the largest digit q in 0..3 with
// q*D <= T and return the new partial remainder T - q*D. Purely combinational.
module radix4_div_step
  import radix4_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] t_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH+1:0] d3_i,
  output logic [1:0]       q_o,
  output logic [WIDTH+1:0] p_o
);

  localparam int PW = WIDTH + 2;

  // Candidate subtrahends 1D, 2D, 3D; all compared at full PW width so that
  // 3D (up to WIDTH+2 bits) never truncates.
  logic [PW-1:0] mult [1:3];
  logic [PW-1:0] diff [1:3];
  logic [3:1]    ge;

  assign mult[1] = PW'(d_i);
  assign mult[2] = PW'({d_i, 1'b0});
  assign mult[3] = d3_i;

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_trial
      assign diff[gi] = t_i - mult[gi];
      assign ge[gi]   = (t_i >= mult[gi]);
    end
  endgenerate

  // Priority select of the largest multiple that still fits under T.
  always_comb begin
    q_o = 2'd0;
    p_o = t_i;
    if (ge[3]) begin
      q_o = 2'd3;
      p_o = diff[3];
    end else if (ge[2]) begin
      q_o = 2'd2;
      p_o = diff[2];
    end else if (ge[1]) begin
      q_o = 2'd1;
      p_o = diff[1];
    end
  end

endmodule

// File: rtl/radix4_divider.sv
// Unsigned iterative radix-4 restoring divider. Retires two quotient bits per
// clock with fixed latency (result strobe ITERS+1 cycles after the request)
// and holds quotient/remainder until the next operation completes.
module radix4_divider
  import radix4_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             input_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             output_valid
);

  localparam int ITERS = WIDTH / 2;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int PW    = WIDTH + 2;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] d_q;
  logic [PW-1:0]    d3_q;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             output_valid_q;

  logic [PW-1:0]    t_d;
  logic [PW-1:0]    p_d;
  logic [1:0]       digit_d;
  logic [WIDTH-1:0] q_d;

  // T = {P, top two dividend bits}; P < D always, so only its low WIDTH bits
  // can be non-zero and the cast drops nothing meaningful.
  assign t_d = PW'({p_q, q_q[WIDTH-1 -: 2]});
  assign q_d = {q_q[WIDTH-3:0], digit_d};

  radix4_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .t_i  (t_d),
    .d_i  (d_q),
    .d3_i (d3_q),
    .q_o  (digit_d),
    .p_o  (p_d)
  );

  // Controller FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= STATE_IDLE;
      cnt_q          <= '0;
      d_q            <= '0;
      d3_q           <= '0;
      p_q            <= '0;
      q_q            <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      output_valid_q <= 1'b0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          output_valid_q <= 1'b0;
          if (input_valid) begin
            d_q     <= divisor;
            d3_q    <= PW'(divisor) + (PW'(divisor) << 1);
            q_q     <= dividend;
            p_q     <= '0;
            cnt_q   <= CNT_W'(ITERS - 1);
            state_q <= STATE_CALC;
          end
        end
        STATE_CALC: begin
          p_q <= p_d;
          q_q <= q_d;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // Last step: publish the result so it is valid in the DONE cycle.
            quotient_q     <= q_d;
            remainder_q    <= WIDTH'(p_d);
            output_valid_q <= 1'b1;
            state_q        <= STATE_DONE;
          end
        end
        STATE_DONE: begin
          output_valid_q <= 1'b0;
          state_q        <= STATE_IDLE;
        end
        default: begin
          output_valid_q <= 1'b0;
          state_q        <= STATE_IDLE;
        end
      endcase
    end
  end

  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign output_valid = output_valid_q;

endmodule

// File: tb/tb_radix4_divider.sv
// Self-checking bench for radix4_divider: directed cases with literal
// expectations plus a randomized soak checked every cycle against an
// arithmetic reference model of results and timing.
module tb_radix4_divider;

  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH / 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             input_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             output_valid;

  int checks;
  int failures;

  radix4_divider #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dividend     (dividend),
    .divisor      (divisor),
    .input_valid  (input_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: divide-by-zero yields all ones / dividend.
  function automatic logic [WIDTH-1:0] ref_quot(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? {WIDTH{1'b1}} : a / b;
  endfunction

  function automatic logic [WIDTH-1:0] ref_rem(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // ---------------- reference model (timing by cycle numbers) -------------
  longint           cyc;
  longint           done_cyc;
  bit               op_active;
  logic [WIDTH-1:0] pend_a, pend_b, pend_q, pend_r;
  logic [WIDTH-1:0] last_q, last_r;

  initial begin
    cyc       = 0;
    done_cyc  = -1;
    op_active = 0;
    last_q    = '0;
    last_r    = '0;
    pend_a    = '0;
    pend_b    = '0;
    pend_q    = '0;
    pend_r    = '0;
  end

  // A request is taken when the cycle it was presented in is past the last
  // result cycle; the result appears ITERS+1 cycles after the request cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      op_active = 0;
      done_cyc  = -1;
      last_q    = '0;
      last_r    = '0;
    end else begin
      cyc = cyc + 1;
      if ((cyc - 1) > done_cyc && input_valid) begin
        op_active = 1;
        done_cyc  = (cyc - 1) + ITERS + 1;
        pend_a    = dividend;
        pend_b    = divisor;
        pend_q    = ref_quot(dividend, divisor);
        pend_r    = ref_rem(dividend, divisor);
      end
      if (op_active && cyc == done_cyc) begin
        last_q = pend_q;
        last_r = pend_r;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", {63'd0, output_valid}, 64'd0);
      check("rst_quot", {32'd0, quotient}, 64'd0);
      check("rst_rem", {32'd0, remainder}, 64'd0);
    end else begin
      check("cyc_valid", {63'd0, output_valid}, {63'd0, (op_active && cyc == done_cyc)});
      if (!(op_active && cyc < done_cyc)) begin
        check("cyc_quot", {32'd0, quotient}, {32'd0, last_q});
        check("cyc_rem", {32'd0, remainder}, {32'd0, last_r});
      end
      if (op_active && cyc == done_cyc) begin
        if (pend_b != 0) begin
          check("inv_recombine", {32'd0, quotient} * {32'd0, pend_b} + {32'd0, remainder},
                {32'd0, pend_a});
          check("inv_rem_lt_div", {63'd0, (remainder < pend_b)}, 64'd1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                       output int lat);
    @(negedge clk);
    dividend    = a;
    divisor     = b;
    input_valid = 1'b1;
    lat = -1;
    q   = '0;
    r   = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) input_valid = 1'b0;
      if (output_valid) begin
        lat = k;
        q   = quotient;
        r   = remainder;
        break;
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] pick_divisor();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return WIDTH'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pick_dividend();
    case ($urandom_range(0, 5))
      0: return WIDTH'($urandom_range(0, 20));
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [WIDTH-1:0] q_r, r_r;
  int               lat_r;
  int               nv, first_k;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    dividend    = '0;
    divisor     = '0;
    input_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Model pins against hand arithmetic.
    check("model_100_7_q", {32'd0, ref_quot(32'd100, 32'd7)}, 64'd14);
    check("model_0div_r", {32'd0, ref_rem(32'h1234_5678, 32'd0)}, 64'h1234_5678);

    // 100 / 7 with hold check.
    do_op(32'd100, 32'd7, q_r, r_r, lat_r);
    check("t1_lat", 64'(lat_r), 64'd17);
    check("t1_q", {32'd0, q_r}, 64'd14);
    check("t1_r", {32'd0, r_r}, 64'd2);
    $display("op 100/7 -> q=%0d r=%0d lat=%0d", q_r, r_r, lat_r);
    repeat (5) @(negedge clk);
    check("t1_hold_q", {32'd0, quotient}, 64'd14);
    check("t1_hold_r", {32'd0, remainder}, 64'd2);
    check("t1_hold_v", {63'd0, output_valid}, 64'd0);

    // All-ones cases.
    do_op(32'hFFFF_FFFF, 32'd1, q_r, r_r, lat_r);
    check("t2a_q", {32'd0, q_r}, 64'hFFFF_FFFF);
    check("t2a_r", {32'd0, r_r}, 64'd0);
    $display("op ffffffff/1 -> q=%0h r=%0h lat=%0d", q_r, r_r, lat_r);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, q_r, r_r, lat_r);
    check("t2b_q", {32'd0, q_r}, 64'd1);
    check("t2b_r", {32'd0, r_r}, 64'd0);
    $display("op ffffffff/ffffffff -> q=%0h r=%0h lat=%0d", q_r, r_r, lat_r);

    // Divide by zero, then dividend < divisor.
    do_op(32'h1234_5678, 32'd0, q_r, r_r, lat_r);
    check("t3a_lat", 64'(lat_r), 64'd17);
    check("t3a_q", {32'd0, q_r}, 64'hFFFF_FFFF);
    check("t3a_r", {32'd0, r_r}, 64'h1234_5678);
    $display("op 12345678/0 -> q=%0h r=%0h lat=%0d", q_r, r_r, lat_r);
    do_op(32'd5, 32'd9, q_r, r_r, lat_r);
    check("t3b_q", {32'd0, q_r}, 64'd0);
    check("t3b_r", {32'd0, r_r}, 64'd5);
    $display("op 5/9 -> q=%0d r=%0d lat=%0d", q_r, r_r, lat_r);

    // 1000 / 3 with ignored requests during CALC and DONE.
    @(negedge clk);
    dividend    = 32'd1000;
    divisor     = 32'd3;
    input_valid = 1'b1;
    nv      = 0;
    first_k = -1;
    q_r     = '0;
    r_r     = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      input_valid = 1'b0;
      if (k == 5) begin
        dividend    = 32'd7;
        divisor     = 32'd7;
        input_valid = 1'b1;
      end
      if (output_valid) begin
        nv++;
        if (first_k < 0) begin
          first_k     = k;
          q_r         = quotient;
          r_r         = remainder;
          dividend    = 32'd7;
          divisor     = 32'd7;
          input_valid = 1'b1;
        end
      end
    end
    input_valid = 1'b0;
    check("t4_lat", 64'(first_k), 64'd17);
    check("t4_count", 64'(nv), 64'd1);
    check("t4_q", {32'd0, q_r}, 64'd333);
    check("t4_r", {32'd0, r_r}, 64'd1);
    $display("op 1000/3 with ignored pulses -> q=%0d r=%0d lat=%0d strobes=%0d", q_r, r_r, first_k, nv);

    // 1000 / 3 aborted by asynchronous reset mid-cycle.
    @(negedge clk);
    dividend    = 32'd1000;
    divisor     = 32'd3;
    input_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      input_valid = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("t5_rst_q", {32'd0, quotient}, 64'd0);
    check("t5_rst_r", {32'd0, remainder}, 64'd0);
    check("t5_rst_v", {63'd0, output_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (output_valid) nv++;
    end
    check("t5_no_strobe", 64'(nv), 64'd0);
    $display("op 1000/3 aborted by reset -> strobes after reset=%0d", nv);
    do_op(32'd81, 32'd9, q_r, r_r, lat_r);
    check("t5_lat", 64'(lat_r), 64'd17);
    check("t5_q", {32'd0, q_r}, 64'd9);
    check("t5_r", {32'd0, r_r}, 64'd0);
    $display("op 81/9 -> q=%0d r=%0d lat=%0d", q_r, r_r, lat_r);

    // Randomized soak; the per-cycle compare process does the checking.
    nv = 0;
    for (int c = 0; c < 36000; c++) begin
      @(negedge clk);
      if (output_valid) nv++;
      input_valid = ($urandom_range(0, 3) != 0);
      dividend    = pick_dividend();
      divisor     = pick_divisor();
    end
    input_valid = 1'b0;
    repeat (ITERS + 4) @(negedge clk);
    $display("soak complete: strobes=%0d", nv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
